fourstate_bus_decoder: RTL

// - Receiving end of the 4-state wor bus: samples a packed [0:4][2:3][2:1] 4-state word (20 bits).
// - Encodes each bit into a 2-bit 2-state symbol (0/1/Z/X).
// - Streams the 40-bit result out as 5 valid/ready beats.
// - Keeps per-design X/Z statistics for bench and debug use.

---
 rtl/fourstate_bus_pkg.sv | 38 +++
 rtl/fourstate_bit_enc.sv | 23 ++
 rtl/fourstate_bus_decoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fourstate_bus_pkg.sv
// Shared types and bit classifiers for the 4-state bus receive path.
package fourstate_bus_pkg;

  typedef enum logic [1:0] {
    SYM_0 = 2'b00,
    SYM_1 = 2'b01,
    SYM_Z = 2'b10,
    SYM_X = 2'b11
  } sym_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam int BUS_W_DEF  = 20;
  localparam int LANE_W_DEF = 4;

  // Only an exact 0 or 1 counts as data; X is told apart from Z by case equality.
  function automatic sym_t enc_bit(logic b);
    sym_t s;
    if (b === 1'b0) begin
      s = SYM_0;
    end else if (b === 1'b1) begin
      s = SYM_1;
    end else if (b === 1'bx) begin
      s = SYM_X;
    end else begin
      s = SYM_Z;
    end
    return s;
  endfunction

  function automatic logic is_xz(logic b);
    return (b !== 1'b0) && (b !== 1'b1);
  endfunction

endpackage

// File: rtl/fourstate_bit_enc.sv
// Combinational encoder: each 4-state bus bit becomes a 2-bit symbol, plus a count of X/Z bits.
module fourstate_bit_enc
  import fourstate_bus_pkg::*;
#(
  parameter int BUS_W = BUS_W_DEF,
  parameter int PC_W  = $clog2(BUS_W + 1)
) (
  input  logic [BUS_W-1:0]   bus,
  output logic [2*BUS_W-1:0] sym,
  output logic [PC_W-1:0]    xz_cnt
);

  // Symbol bit 1 is set exactly for Z and X, so it doubles as the X/Z tally input.
  always_comb begin
    sym    = '0;
    xz_cnt = '0;
    for (int i = 0; i < BUS_W; i++) begin
      sym[2*i +: 2] = enc_bit(bus[i]);
      xz_cnt        = xz_cnt + PC_W'(sym[2*i+1]);
    end
  end

endmodule

// File: rtl/fourstate_bus_decoder.sv
// Samples a 4-state bus frame, streams its symbol encoding out as valid/ready beats,
// and keeps X/Z and frame statistics.
module fourstate_bus_decoder
  import fourstate_bus_pkg::*;
#(
  parameter int BUS_W  = BUS_W_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BUS_W-1:0]    in_bus,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [2*LANE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [CNT_W-1:0]    xz_count,
  output logic [CNT_W-1:0]    frame_count,
  output logic                ctl_err
);

  localparam int                NBEATS    = BUS_W / LANE_W;
  localparam int                BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int                PC_W      = $clog2(BUS_W + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [2*BUS_W-1:0] sym_q, sym_d;
  logic [2*BUS_W-1:0] enc_sym;
  logic [PC_W-1:0]    enc_xz;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   xz_q, xz_d;
  logic [CNT_W-1:0]   frame_q, frame_d;
  logic               ctl_err_q, ctl_err_d;
  logic               accept;
  logic               xfer;
  logic [31:0]        xz_sum;

  fourstate_bit_enc #(
    .BUS_W (BUS_W),
    .PC_W  (PC_W)
  ) u_enc (
    .bus    (in_bus),
    .sym    (enc_sym),
    .xz_cnt (enc_xz)
  );

  // Handshakes only fire on an exact 1; an X/Z control bit is a no-handshake cycle that flags ctl_err.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    sym_d     = sym_q;
    xz_d      = xz_q;
    frame_d   = frame_q;
    accept    = in_ready_q && (in_valid === 1'b1);
    xfer      = (state_q == ST_SEND) && (out_ready === 1'b1);
    xz_sum    = 32'(xz_q) + 32'(enc_xz);
    if ((in_ready_q && is_xz(in_valid)) || ((state_q == ST_SEND) && is_xz(out_ready))) begin
      ctl_err_d = 1'b1;
    end else begin
      ctl_err_d = ctl_err_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SEND;
          beat_d  = '0;
          sym_d   = enc_sym;
          frame_d = frame_q + CNT_W'(1'b1);
          xz_d    = (xz_sum > 32'(CNT_MAX)) ? CNT_MAX : CNT_W'(xz_sum);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        // The current beat always sits in the top lane of sym_q; a transfer shifts the next one up.
        if (xfer) begin
          sym_d = sym_q << (2 * LANE_W);
          if (beat_q == LAST_BEAT) begin
            state_d = ST_IDLE;
            beat_d  = '0;
          end else begin
            state_d = ST_SEND;
            beat_d  = beat_q + BEAT_W'(1'b1);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State, capture and statistics registers; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      sym_q      <= '0;
      in_ready_q <= 1'b0;
      xz_q       <= '0;
      frame_q    <= '0;
      ctl_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      sym_q      <= sym_d;
      in_ready_q <= in_ready_d;
      xz_q       <= xz_d;
      frame_q    <= frame_d;
      ctl_err_q  <= ctl_err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q == ST_SEND);
  assign out_last    = (state_q == ST_SEND) && (beat_q == LAST_BEAT);
  assign out_data    = sym_q[2*BUS_W-1 -: 2*LANE_W];
  assign xz_count    = xz_q;
  assign frame_count = frame_q;
  assign ctl_err     = ctl_err_q;

endmodule
